nrs_gold_seq_gen: RTL
=====================

NRS_GOLD_SEQ_GEN -- requirements
Module: nrs_gold_seq_gen

Interface
REQ-001 SHALL have parameter NC, default 1600: Gold-sequence warm-up offset in bits.
REQ-002 SHALL have parameter SKIP, default 218: extra bits discarded after NC, i.e. c(2*(N_RB_maxDL-1)) start index.
REQ-003 SHALL have parameter NUM_BITS, default 4: c(n) bits emitted per request.
REQ-004 SHALL have parameter CINIT_W, default 28: width of cinit input.
REQ-005 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide cinit  input  CINIT_W  scrambling init value from cinit generator.
REQ-008 SHALL provide cinit_valid  input  1  cinit qualifier; one-cycle pulse or level.
REQ-009 SHALL provide ready  output  1  high only in IDLE; new cinit accepted.
REQ-010 SHALL provide seq_bit  output  1  registered c(n) bit.
REQ-011 SHALL provide seq_valid  output  1  seq_bit qualifier.
REQ-012 SHALL provide seq_last  output  1  high with the final bit of a request.

Function
REQ-013 SHALL hold two 31-bit LFSRs x1, x2; x1(n+31)=x1(n+3)^x1(n); x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n); bit [0] is x(n).
REQ-014 SHALL compute c(n)=x1(n+NC)^x2(n+NC).
REQ-015 SHALL implement FSM states IDLE, WARMUP, OUTPUT; IDLE after reset.
REQ-016 In IDLE with cinit_valid=1 at an edge (load edge, E0), SHALL load x1=31'h1, x2={zero-extend cinit}, clear counter, go to WARMUP.
REQ-017 In WARMUP SHALL advance both LFSRs one step per cycle for exactly NC+SKIP edges (E1..E(NC+SKIP)), then enter OUTPUT at edge E(NC+SKIP).
REQ-018 If NC+SKIP=0, SHALL go from IDLE directly to OUTPUT at E0.
REQ-019 In OUTPUT each edge SHALL register seq_bit=x1[0]^x2[0], set seq_valid=1, and advance the LFSRs; NUM_BITS consecutive edges.
REQ-020 First valid bit, c(SKIP), SHALL be registered at edge E(NC+SKIP+1); bit k, c(SKIP+k), at E(NC+SKIP+1+k); no gaps.
REQ-021 seq_last SHALL be 1 only with bit NUM_BITS-1; at that edge FSM SHALL return to IDLE.
REQ-022 seq_valid and seq_last SHALL be 0 on every edge not registering a bit; seq_bit holds its last value when not valid.
REQ-023 cinit_valid while not IDLE SHALL be ignored, with no restart and no queuing.
REQ-024 A new load SHALL be accepted on the edge immediately after the edge carrying seq_last (ready=1 that cycle); back-to-back requests allowed.
REQ-025 The warm-up counter SHALL be at least 12 bits; NC+SKIP up to 4095 and NUM_BITS up to 255 supported; counter SHALL not wrap within a request.
REQ-026 Only cinit[CINIT_W-1:0] SHALL be used; x2 bits 30..CINIT_W SHALL load 0.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, x1=31'h1, x2=0, counter=0, seq_bit=0, seq_valid=0, seq_last=0, ready=1.
REQ-028 Reset asserted mid-WARMUP or mid-OUTPUT SHALL abort the request with no further seq_valid; after release, the first edge with cinit_valid=1 starts a fresh request.
REQ-029 Outputs SHALL not glitch to valid during or on release of reset.

Verification
REQ-030 NC=0, SKIP=0, NUM_BITS=4, cinit=0 -> seq_bit 1,0,0,0 at E1..E4, seq_last at E4, ready high from the cycle after E4.
REQ-031 NC=0, SKIP=0, cinit=1 -> 0,0,0,0; cinit=2 -> 1,1,0,0; cinit=28'hFFFFFFF -> bit-exact match to C model.
REQ-032 Defaults, cinit from cinit generator for N_cell_ID=0, slot=0 -> first seq_valid at E1819, 4 bits equal to model c(218..221), seq_last at E1822.
REQ-033 cinit_valid pulsed at E0 and again at E500 (WARMUP) -> only one request; output timing unchanged; ready low E1..E1822.
REQ-034 rst low at E1000 of a default request -> all outputs at reset values immediately; no seq_valid; new request after release completes with correct bits.
REQ-035 Back-to-back: cinit_valid held high -> second load on the edge after seq_last; second output burst begins NC+SKIP+1 edges later, bits correct.

Source files
------------

// File: rtl/nrs_gold_seq_gen.sv
// Gold-sequence c(n) generator: loads cinit, runs NC+SKIP warm-up steps,
// then emits NUM_BITS registered scrambling bits per request.
module nrs_gold_seq_gen #(
    parameter int unsigned NC       = 1600,
    parameter int unsigned SKIP     = 218,
    parameter int unsigned NUM_BITS = 4,
    parameter int unsigned CINIT_W  = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CINIT_W-1:0] cinit,
    input  logic               cinit_valid,
    output logic               ready,
    output logic               seq_bit,
    output logic               seq_valid,
    output logic               seq_last
);

    localparam int unsigned LFSR_W = 31;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned WARM   = NC + SKIP;

    // WARM_LAST is only reached when WARM > 0, so the wrap at WARM == 0 is harmless
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t             state;
    logic [LFSR_W-1:0]  x1;
    logic [LFSR_W-1:0]  x2;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W-1:0]  x1_step;
    logic [LFSR_W-1:0]  x2_step;

    // One recursion step: bit [0] is x(n), the new x(n+31) enters at bit [30]
    assign x1_step = {x1[3] ^ x1[0], x1[LFSR_W-1:1]};
    assign x2_step = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[LFSR_W-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x1        <= LFSR_W'(1);
            x2        <= '0;
            cnt       <= '0;
            seq_bit   <= 1'b0;
            seq_valid <= 1'b0;
            seq_last  <= 1'b0;
            ready     <= 1'b1;
        end else begin
            seq_valid <= 1'b0;
            seq_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cinit_valid) begin
                        x1    <= LFSR_W'(1);
                        x2    <= LFSR_W'(cinit);
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= (WARM == 0) ? OUTPUT : WARMUP;
                    end
                end
                WARMUP: begin
                    x1 <= x1_step;
                    x2 <= x2_step;
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= OUTPUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUTPUT: begin
                    seq_bit   <= x1[0] ^ x2[0];
                    seq_valid <= 1'b1;
                    x1        <= x1_step;
                    x2        <= x2_step;
                    if (cnt == OUT_LAST) begin
                        cnt      <= '0;
                        seq_last <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
